// File: rtl/complex_mult_pkg.sv
// Shared definitions for the complex multiplier engine: FSM state encoding,
// result width and fixed operation latency.
package complex_mult_pkg;

    // Engine sequencing: accept, two multiply passes, present result
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_1 = 2'd1,
        MUL_2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of res_re/res_im; one bit above a product so the sum or
    // difference of two products can never wrap.
    function automatic int RES_WIDTH(input int dw);
        return 2 * dw + 1;
    endfunction

    // Cycles from the accepting edge to the edge that enters DONE
    function automatic int LATENCY_CYCLES(input int dw);
        return 2 * dw + 2;
    endfunction

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_LATENCY    = LATENCY_CYCLES(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/seq_signed_mult.sv
// Sequential signed shift-add multiplier. Multiplies operand magnitudes one
// bit per cycle and negates at the end when the signs differ. A start pulse
// loads x/y; exactly DATA_WIDTH cycles later product is updated and done
// pulses for one cycle.
module seq_signed_mult #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           sw_rst,
    input  logic                           start,
    input  logic signed [DATA_WIDTH-1:0]   x,
    input  logic signed [DATA_WIDTH-1:0]   y,
    output logic signed [2*DATA_WIDTH-1:0] product,
    output logic                           done
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [2*DATA_WIDTH-1:0]        mcand_reg;
    logic [2*DATA_WIDTH-1:0]        acc_reg;
    logic [2*DATA_WIDTH-1:0]        acc_next;
    logic [DATA_WIDTH-1:0]          mplier_reg;
    logic [DATA_WIDTH-1:0]          x_mag;
    logic [DATA_WIDTH-1:0]          y_mag;
    logic [CW-1:0]                  cnt_reg;
    logic                           busy_reg;
    logic                           neg_reg;
    logic                           done_reg;
    logic signed [2*DATA_WIDTH-1:0] product_reg;

    // Operand magnitudes (-2^(W-1) maps to 2^(W-1), which fits unsigned) and
    // the next partial sum
    always_comb begin
        x_mag    = x[DATA_WIDTH-1] ? $unsigned(-x) : $unsigned(x);
        y_mag    = y[DATA_WIDTH-1] ? $unsigned(-y) : $unsigned(y);
        acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    end

    // Load on start, then one shift-add step per cycle; last step applies sign
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcand_reg   <= '0;
            acc_reg     <= '0;
            mplier_reg  <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            neg_reg     <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else if (sw_rst) begin
            mcand_reg   <= '0;
            acc_reg     <= '0;
            mplier_reg  <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            neg_reg     <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                mcand_reg  <= {{DATA_WIDTH{1'b0}}, x_mag};
                mplier_reg <= y_mag;
                acc_reg    <= '0;
                neg_reg    <= x[DATA_WIDTH-1] ^ y[DATA_WIDTH-1];
                cnt_reg    <= CW'(DATA_WIDTH);
                busy_reg   <= 1'b1;
            end else if (busy_reg) begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b1;
                    product_reg <= neg_reg ? -$signed(acc_next) : $signed(acc_next);
                end
            end
        end
    end

    assign product = product_reg;
    assign done    = done_reg;

endmodule

// File: rtl/complex_mult_engine.sv
// Complex multiplier engine: (a+jb)*(c+jd) using two sequential multipliers
// over two passes (ac/bd, then ad/bc). Optional macro COMPLEX_MULT_CONJ_EN
// adds op_2_conj to multiply by the conjugate of op_2 instead.
module complex_mult_engine
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  sw_rst,
    input  logic                                  op_val,
    output logic                                  op_ready,
    input  logic signed [DATA_WIDTH-1:0]          op_1_re,
    input  logic signed [DATA_WIDTH-1:0]          op_1_im,
    input  logic signed [DATA_WIDTH-1:0]          op_2_re,
    input  logic signed [DATA_WIDTH-1:0]          op_2_im,
`ifdef COMPLEX_MULT_CONJ_EN
    input  logic                                  op_2_conj,
`endif
    output logic                                  res_val,
    input  logic                                  res_ready,
    output logic signed [RES_WIDTH(DATA_WIDTH)-1:0] res_re,
    output logic signed [RES_WIDTH(DATA_WIDTH)-1:0] res_im
);
    localparam int RW = RES_WIDTH(DATA_WIDTH);
    localparam int PW = 2 * DATA_WIDTH;

    state_t                  state_reg, state_next;
    logic signed [DATA_WIDTH-1:0] a_reg, b_reg, c_reg, d_reg;
    logic signed [DATA_WIDTH-1:0] m0_x, m0_y, m1_x, m1_y;
    logic signed [PW-1:0]    p_ac_reg, p_bd_reg;
    logic signed [PW-1:0]    mul0_product, mul1_product;
    logic                    mul0_done, mul1_done, mul_done, mul_start;
    logic signed [RW-1:0]    res_re_reg, res_im_reg;
    logic signed [RW-1:0]    ac_ext, bd_ext, ad_ext, bc_ext, re_calc, im_calc;
    logic                    conj_sel;

`ifdef COMPLEX_MULT_CONJ_EN
    logic conj_reg;

    // Conjugate select is captured with the operands
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                          conj_reg <= 1'b0;
        else if (sw_rst)                    conj_reg <= 1'b0;
        else if (state_reg == IDLE && op_val) conj_reg <= op_2_conj;
    end
    assign conj_sel = conj_reg;
`else
    assign conj_sel = 1'b0;
`endif

    assign mul_done = mul0_done & mul1_done;

    // Next state, handshake outputs and multiplier start/operand steering.
    // Pass 1 starts on the accepting edge straight from the input ports so
    // the two passes fit in 2*DATA_WIDTH+2 cycles; pass 2 uses held operands.
    always_comb begin
        state_next = state_reg;
        mul_start  = 1'b0;
        m0_x       = a_reg;
        m0_y       = d_reg;
        m1_x       = b_reg;
        m1_y       = c_reg;
        unique case (state_reg)
            IDLE: begin
                m0_x = op_1_re;
                m0_y = op_2_re;
                m1_x = op_1_im;
                m1_y = op_2_im;
                if (op_val) begin
                    state_next = MUL_1;
                    mul_start  = 1'b1;
                end
            end
            MUL_1: begin
                if (mul_done) begin
                    state_next = MUL_2;
                    mul_start  = 1'b1;
                end
            end
            MUL_2: begin
                if (mul_done) state_next = DONE;
            end
            DONE: begin
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       state_reg <= IDLE;
        else if (sw_rst) state_reg <= IDLE;
        else             state_reg <= state_next;
    end

    // Combine the four sign-extended products into the result
    always_comb begin
        ac_ext = {p_ac_reg[PW-1], p_ac_reg};
        bd_ext = {p_bd_reg[PW-1], p_bd_reg};
        ad_ext = {mul0_product[PW-1], mul0_product};
        bc_ext = {mul1_product[PW-1], mul1_product};
        if (conj_sel) begin
            re_calc = ac_ext + bd_ext;
            im_calc = bc_ext - ad_ext;
        end else begin
            re_calc = ac_ext - bd_ext;
            im_calc = ad_ext + bc_ext;
        end
    end

    // Operand capture, pass-1 product holding and result registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_reg <= '0; b_reg <= '0; c_reg <= '0; d_reg <= '0;
            p_ac_reg <= '0; p_bd_reg <= '0;
            res_re_reg <= '0; res_im_reg <= '0;
        end else if (sw_rst) begin
            a_reg <= '0; b_reg <= '0; c_reg <= '0; d_reg <= '0;
            p_ac_reg <= '0; p_bd_reg <= '0;
            res_re_reg <= '0; res_im_reg <= '0;
        end else begin
            if (state_reg == IDLE && op_val) begin
                a_reg <= op_1_re;
                b_reg <= op_1_im;
                c_reg <= op_2_re;
                d_reg <= op_2_im;
            end
            if (state_reg == MUL_1 && mul_done) begin
                p_ac_reg <= mul0_product;
                p_bd_reg <= mul1_product;
            end
            if (state_reg == MUL_2 && mul_done) begin
                res_re_reg <= re_calc;
                res_im_reg <= im_calc;
            end
        end
    end

    seq_signed_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mul0 (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .start(mul_start),
        .x(m0_x), .y(m0_y), .product(mul0_product), .done(mul0_done)
    );

    seq_signed_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mul1 (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .start(mul_start),
        .x(m1_x), .y(m1_y), .product(mul1_product), .done(mul1_done)
    );

    assign op_ready = (state_reg == IDLE);
    assign res_val  = (state_reg == DONE);
    assign res_re   = res_re_reg;
    assign res_im   = res_im_reg;

endmodule

// File: tb/tb_complex_mult_engine.sv
// Self-checking bench for complex_mult_engine: directed corners, handshake
// and reset scenarios plus randomized transactions against a plain
// arithmetic model of the complex product.
module tb_complex_mult_engine;
    localparam int DW  = 8;
    localparam int RW  = 2 * DW + 1;
    localparam int LAT = 2 * DW + 2;

    logic                 clk;
    logic                 rstn;
    logic                 sw_rst;
    logic                 op_val;
    logic                 op_ready;
    logic signed [DW-1:0] op_1_re, op_1_im, op_2_re, op_2_im;
    logic                 op_2_conj;
    logic                 res_val;
    logic                 res_ready;
    logic signed [RW-1:0] res_re, res_im;

    int checks   = 0;
    int failures = 0;

    complex_mult_engine #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
        .op_val(op_val), .op_ready(op_ready),
        .op_1_re(op_1_re), .op_1_im(op_1_im),
        .op_2_re(op_2_re), .op_2_im(op_2_im),
`ifdef COMPLEX_MULT_CONJ_EN
        .op_2_conj(op_2_conj),
`endif
        .res_val(res_val), .res_ready(res_ready),
        .res_re(res_re), .res_im(res_im)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_equal(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rand_operands();
        logic [31:0] r;
        r = $urandom;
        op_1_re = r[7:0]; op_1_im = r[15:8]; op_2_re = r[23:16]; op_2_im = r[31:24];
    endtask

    // Watch for a spurious result over a number of cycles
    task automatic idle_watch(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); @(negedge clk);
            if (res_val) seen = 1'b1;
        end
        check_equal(tag, seen, 0);
    endtask

    // One transaction: hold_val = extra edges op_val stays high, stall = cycles
    // res_ready stays low in DONE, early = res_ready high from acceptance,
    // complete = 0 leaves the engine sitting in DONE.
    task automatic run_txn(input string tag,
                           input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                           input logic signed [DW-1:0] c, input logic signed [DW-1:0] d,
                           input logic conj, input int hold_val, input int stall,
                           input logic early, input logic complete);
        longint er, ei;
        int     n;
        logic   stable;
        if (conj) begin
            er = longint'(a) * longint'(c) + longint'(b) * longint'(d);
            ei = longint'(b) * longint'(c) - longint'(a) * longint'(d);
        end else begin
            er = longint'(a) * longint'(c) - longint'(b) * longint'(d);
            ei = longint'(a) * longint'(d) + longint'(b) * longint'(c);
        end
        n = 0;
        while (!op_ready && n < 50) begin
            @(negedge clk); n++;
        end
        check_equal({tag, "_ready_in"}, op_ready, 1);
        op_1_re = a; op_1_im = b; op_2_re = c; op_2_im = d;
        op_2_conj = conj;
        op_val    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = early;
        if (hold_val == 0) begin
            op_val = 1'b0;
            rand_operands();
            op_2_conj = ~conj;
        end
        check_equal({tag, "_busy"}, op_ready, 0);
        n = 0;
        while (!res_val && n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (n >= hold_val && op_val) begin
                op_val = 1'b0;
                rand_operands();
                op_2_conj = ~conj;
            end
        end
        check_equal({tag, "_latency"}, n, LAT);
        check_equal({tag, "_re"}, res_re, er);
        check_equal({tag, "_im"}, res_im, ei);
        $display("txn %s a=%0d b=%0d c=%0d d=%0d conj=%0d -> re=%0d im=%0d lat=%0d",
                 tag, a, b, c, d, conj, res_re, res_im, n);
        if (complete) begin
            if (!early) begin
                stable = 1'b1;
                repeat (stall) begin
                    @(posedge clk); @(negedge clk);
                    if (res_val !== 1'b1 || res_re != er || res_im != ei) stable = 1'b0;
                end
                check_equal({tag, "_stall"}, stable, 1);
                res_ready = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            res_ready = 1'b0;
            check_equal({tag, "_val_clr"}, res_val, 0);
            check_equal({tag, "_ready_out"}, op_ready, 1);
            check_equal({tag, "_hold_re"}, res_re, er);
        end
    endtask

    initial begin
        logic [31:0]          r;
        logic signed [DW-1:0] ra, rb, rc, rd;
        logic                 rconj;

        rstn = 1'b0; sw_rst = 1'b0; op_val = 1'b0; res_ready = 1'b0;
        op_1_re = '0; op_1_im = '0; op_2_re = '0; op_2_im = '0; op_2_conj = 1'b0;
        #12;
        check_equal("rst_op_ready", op_ready, 1);
        check_equal("rst_res_val", res_val, 0);
        check_equal("rst_res_re", res_re, 0);
        check_equal("rst_res_im", res_im, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Directed products
        run_txn("basic",    2,    3,    4,    5, 0, 0, 0, 0, 1);
        run_txn("ones",    -1,   -1,   -1,   -1, 0, 0, 0, 0, 1);
        run_txn("corner", -128, -128, -128, -128, 0, 0, 0, 0, 1);
        run_txn("maxpos", 127, -128, 127, 127, 0, 0, 0, 0, 1);

        // Handshake behaviour
        run_txn("hold_val", 5, -7, 3, 2, 0, 1, 0, 0, 1);
        idle_watch("hold_val_single", 2 * LAT);
        run_txn("stall20", -9, 4, 11, -6, 0, 0, 20, 0, 1);
        run_txn("early_rdy", 13, -2, -8, 7, 0, 0, 0, 1, 1);

        // sw_rst while in MUL_1: transaction is discarded
        run_txn("pre_sw", 6, 6, 6, 6, 0, 0, 0, 0, 1);
        op_1_re = 10; op_1_im = 10; op_2_re = 10; op_2_im = 10;
        op_val = 1'b1;
        @(posedge clk); @(negedge clk);
        op_val = 1'b0;
        sw_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        sw_rst = 1'b0;
        check_equal("sw_rst_ready", op_ready, 1);
        check_equal("sw_rst_val", res_val, 0);
        check_equal("sw_rst_re", res_re, 0);
        check_equal("sw_rst_im", res_im, 0);
        idle_watch("sw_rst_no_result", 2 * LAT);

        // sw_rst wins over a simultaneous op_val in IDLE
        op_val = 1'b1; sw_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        op_val = 1'b0; sw_rst = 1'b0;
        check_equal("sw_rst_vs_val", op_ready, 1);
        idle_watch("sw_rst_vs_val_idle", LAT + 4);

        // rstn asserted while holding a result in DONE clears without a clock
        run_txn("pre_rstn", 7, -3, 5, 9, 0, 0, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check_equal("rstn_val", res_val, 0);
        check_equal("rstn_ready", op_ready, 1);
        check_equal("rstn_re", res_re, 0);
        check_equal("rstn_im", res_im, 0);
        @(negedge clk);
        rstn = 1'b1;
        idle_watch("rstn_no_result", LAT + 4);

`ifdef COMPLEX_MULT_CONJ_EN
        run_txn("conj", 2, 3, 4, 5, 1, 0, 0, 0, 1);
`endif

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            ra = r[7:0]; rb = r[15:8]; rc = r[23:16]; rd = r[31:24];
`ifdef COMPLEX_MULT_CONJ_EN
            rconj = $urandom_range(0, 1) == 1;
`else
            rconj = 1'b0;
`endif
            run_txn($sformatf("rand%0d", i), ra, rb, rc, rd, rconj,
                    $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 3) == 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
